// File: rtl/ret_stack_pkg.sv
// Shared definitions for the return-address stack: entry layout, op decode
// and the return-target helper.
package ret_stack_pkg;

  localparam int AW_DEF  = 10;
  localparam int ENTRY_W = AW_DEF + 1;  // tag bit in the MSB

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

  // Caller keeps the low AW bits, which makes the call case wrap modulo 2^AW.
  function automatic logic [63:0] next_ret(input logic [63:0] addr, input logic irq);
    return irq ? addr : addr + 64'd1;
  endfunction

endpackage

// File: rtl/ret_stack_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module ret_stack_mem
  import ret_stack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int EW    = ENTRY_W,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ret_stack.sv
// Return-address stack: occupancy count, sticky error flags, op decode and
// the zero-latency return-target mux.
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic          push_irq,
  input  logic          err_clr,
  output logic [AW-1:0] ret_addr,
  output logic          top_irq,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int EW = AW + 1;
  localparam int IW = $clog2(DEPTH);

  op_e           op;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] top_idx;
  logic [CW-1:0] wr_idx;
  logic          wr_en;
  logic          ovf_evt;
  logic          udf_evt;
  logic [IW-1:0] raddr;
  logic [EW-1:0] rdata;
  logic [63:0]   target;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign top_idx = count - CW'(1);
  assign op      = op_e'({push, pop});

  always_comb begin
    count_nxt = count;
    wr_idx    = count;
    wr_en     = 1'b0;
    ovf_evt   = 1'b0;
    udf_evt   = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_evt = 1'b1;
        end else begin
          wr_en     = 1'b1;
          count_nxt = count + CW'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          udf_evt = 1'b1;
        end else begin
          count_nxt = top_idx;
        end
      end
      OP_SWAP: begin
        // On an empty stack the push still lands; only the pop is rejected.
        wr_en = 1'b1;
        if (empty) begin
          udf_evt   = 1'b1;
          count_nxt = CW'(1);
        end else begin
          wr_idx = top_idx;
        end
      end
      default: begin
        count_nxt = count;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      overflow  <= ovf_evt | (overflow & ~err_clr);
      underflow <= udf_evt | (underflow & ~err_clr);
    end
  end

  // Empty stack reads index 0 so the read stays in range; result is masked.
  assign raddr = empty ? IW'(0) : top_idx[IW-1:0];

  ret_stack_mem #(.DEPTH(DEPTH), .EW(EW), .IW(IW)) u_mem (
    .clk   (clk),
    .we    (wr_en & ~reset),
    .waddr (wr_idx[IW-1:0]),
    .wdata ({push_irq, push_addr}),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign target   = next_ret(64'(rdata[AW-1:0]), rdata[AW]);
  assign top_irq  = empty ? 1'b0 : rdata[AW];
  assign ret_addr = empty ? AW'(0) : target[AW-1:0];

endmodule

// File: tb/tb_ret_stack.sv
// Self-checking bench for ret_stack: directed scenarios plus random traffic
// compared against a queue-based model of the stack.
module tb_ret_stack;

  localparam int AW    = 10;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic          push_irq = 1'b0;
  logic          err_clr = 1'b0;
  logic [AW-1:0] ret_addr;
  logic          top_irq;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of {irq, addr}, back of queue is the top.
  logic [AW:0] m_stk [$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;

  ret_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .push_addr(push_addr), .push_irq(push_irq), .err_clr(err_clr),
    .ret_addr(ret_addr), .top_irq(top_irq), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] exp_ret();
    logic [AW:0] e;
    if (m_stk.size() == 0) return '0;
    e = m_stk[m_stk.size()-1];
    return e[AW] ? e[AW-1:0] : AW'((32'(e[AW-1:0]) + 32'd1) % 32'd1024);
  endfunction

  function automatic logic exp_irq();
    logic [AW:0] e;
    if (m_stk.size() == 0) return 1'b0;
    e = m_stk[m_stk.size()-1];
    return e[AW];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_stk.size()));
    check({tag, ".empty"}, 32'(empty), 32'(m_stk.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(m_stk.size() == DEPTH));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    check({tag, ".ret"}, 32'(ret_addr), 32'(exp_ret()));
    check({tag, ".irq"}, 32'(top_irq), 32'(exp_irq()));
  endtask

  task automatic model_update(input logic r, input logic p, input logic q,
                              input logic [AW-1:0] a, input logic irq, input logic clr);
    logic oe, ue;
    int   n;
    oe = 1'b0;
    ue = 1'b0;
    n  = m_stk.size();
    if (r) begin
      m_stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (p && !q) begin
        if (n == DEPTH) oe = 1'b1;
        else m_stk.push_back({irq, a});
      end else if (!p && q) begin
        if (n == 0) ue = 1'b1;
        else void'(m_stk.pop_back());
      end else if (p && q) begin
        if (n == 0) begin
          ue = 1'b1;
          m_stk.push_back({irq, a});
        end else begin
          m_stk[n-1] = {irq, a};
        end
      end
      m_ovf = oe | (m_ovf & ~clr);
      m_udf = ue | (m_udf & ~clr);
    end
  endtask

  // Called at a negedge: drives inputs, checks the zero-latency outputs,
  // clocks once and checks the updated state at the next negedge.
  task automatic op(input string tag, input logic r, input logic p, input logic q,
                    input logic [AW-1:0] a, input logic irq, input logic clr);
    reset = r; push = p; pop = q; push_addr = a; push_irq = irq; err_clr = clr;
    #1;
    check({tag, ".pre_ret"}, 32'(ret_addr), 32'(exp_ret()));
    @(posedge clk);
    model_update(r, p, q, a, irq, clr);
    @(negedge clk);
    reset = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    @(negedge clk);
    op("reset", 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);

    op("push100", 1'b0, 1'b1, 1'b0, 10'h100, 1'b0, 1'b0);
    op("push200", 1'b0, 1'b1, 1'b0, 10'h200, 1'b1, 1'b0);
    check("tp1.ret", 32'(ret_addr), 32'h200);
    check("tp1.count", 32'(count), 32'd2);
    op("pop1", 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0);
    check("tp1.pop_ret", 32'(ret_addr), 32'h101);
    op("pop2", 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0);

    op("wrap", 1'b0, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
    check("wrap.ret", 32'(ret_addr), 32'h000);

    for (int i = 1; i < DEPTH; i++) begin
      op("fill", 1'b0, 1'b1, 1'b0, AW'($urandom_range(0, 1023)), 1'(i % 2), 1'b0);
    end
    op("ovf", 1'b0, 1'b1, 1'b0, 10'h055, 1'b0, 1'b0);
    check("ovf.flag", 32'(overflow), 32'd1);
    check("ovf.count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      op("drain", 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0);
    end

    op("udf_clr", 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
    check("udf.flag", 32'(underflow), 32'd1);
    op("clr", 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1);
    check("clr.flag", 32'(underflow), 32'd0);

    for (int i = 0; i < DEPTH; i++) begin
      op("fill2", 1'b0, 1'b1, 1'b0, AW'(i * 7), 1'b1, 1'b1);
    end
    op("swap_full", 1'b0, 1'b1, 1'b1, 10'h0AA, 1'b0, 1'b0);
    check("swap_full.ret", 32'(ret_addr), 32'h0AB);
    check("swap_full.ovf", 32'(overflow), 32'd0);
    op("rst_empty", 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    op("swap_empty", 1'b0, 1'b1, 1'b1, 10'h010, 1'b0, 1'b0);
    check("swap_empty.count", 32'(count), 32'd1);
    check("swap_empty.udf", 32'(underflow), 32'd1);

    op("p2", 1'b0, 1'b1, 1'b0, 10'h020, 1'b1, 1'b0);
    op("p3", 1'b0, 1'b1, 1'b0, 10'h030, 1'b0, 1'b0);
    op("rst_push", 1'b1, 1'b1, 1'b0, 10'h040, 1'b0, 1'b0);
    check("rst_push.empty", 32'(empty), 32'd1);

    for (int i = 0; i < 600; i++) begin
      int          sel;
      logic        p, q, r, clr;
      sel = int'($urandom_range(0, 99));
      p   = (sel < 60) ? (i % 200 < 120) : (sel < 85);
      q   = (sel >= 40) ? (i % 200 >= 100) : ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 9) == 0);
      op("rand", r, p, q, AW'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), clr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
